vram_bus_responder: RTL
=======================

# vram_bus_responder

Responder end of the 32-bit VRAM read bus that the layer renderers and the host interface master. Serves two masters: port 0 is the display fetch path (layer renderer, read-only) and port 1 is the host/CPU path (read/write with byte enables). It arbitrates them round-robin onto one single-port synchronous 32-bit VRAM and returns a one-cycle `ack` together with read data. It sits between the renderers/host bridge and the VRAM macro.

## Interface
Parameters:
- `ADDR_W`, 18: byte-address width. VRAM depth is 2^(ADDR_W-2) words of 32 bits, i.e. 256 KB at the default.

Ports:
- `clk`  in  1  system clock, single clock domain.
- `rst`  in  1  synchronous, active-high reset (already decided).
- `m0_addr`  in  ADDR_W  port 0 byte address; bits [1:0] ignored.
- `m0_strobe`  in  1  port 0 request. The master holds it until ack and may drop it combinationally in the ack cycle.
- `m0_rddata`  out  32  port 0 read data, valid only while `m0_ack`=1.
- `m0_ack`  out  1  port 0 completion pulse, one cycle.
- `m1_addr`  in  ADDR_W  port 1 byte address; bits [1:0] ignored.
- `m1_strobe`  in  1  port 1 request, same rules as port 0.
- `m1_write`  in  1  1 = write, 0 = read. Sampled with the request.
- `m1_wrbytesel`  in  4  byte enables, bit i covers bits [8i+7:8i].
- `m1_wrdata`  in  32  write data.
- `m1_rddata`  out  32  port 1 read data, valid only while `m1_ack`=1.
- `m1_ack`  out  1  port 1 completion pulse, one cycle.

## Operation
- FSM has two states, IDLE and ACK. Reset enters IDLE.
- IDLE:
  - If any strobe is high, select a winner.
  - Drive the winner's word address `addr[ADDR_W-1:2]` to the RAM combinationally. For port 1 also drive its write enable, byte enables and data. The RAM samples at the end of this cycle.
  - Latch the grant in `grant_r`, set `last_grant_r` <= winner, go to ACK.
  - If no strobe is high, stay in IDLE and keep RAM write enable at 0.
- ACK:
  - Assert `ack` for `grant_r` only.
  - Both `rddata` outputs carry the RAM read output. Writes also ack; their `rddata` is don't-care.
  - Always return to IDLE. Strobes seen during ACK are ignored; they are re-evaluated in the next IDLE cycle.
- Arbitration:
  - If only one strobe is high, that port wins.
  - If both are high, the port that is not `last_grant_r` wins.
  - `last_grant_r` resets to 1, so port 0 wins the first contention.
- The read-data path is one shared RAM output register. Its reset value is 0.
- RAM contents are not cleared by reset.
- Address arithmetic: word index = `addr >> 2`, no offset and no wrap logic. The top word is `{ADDR_W-2{1'b1}}`.

## Timing
- Strobe is first seen in IDLE in cycle t, so `ack` is high in cycle t+1. That is one cycle of latency.
- Peak throughput is one transaction every 2 cycles.
- Under continuous contention the grants alternate 0,1,0,1. Each port's worst-case latency is 3 cycles from strobe to ack.
- A write committed at cycle t is visible to any read whose IDLE grant is at cycle t+2 or later, including a read from the other port at the same word.
- A strobe dropped before it is granted produces no transaction and no ack.
- Reset asserted in either state:
  - Next cycle both `ack` = 0, `rddata` = 0, state = IDLE, `last_grant_r` = 1.
  - A write granted before reset stays committed. The in-flight ack is lost, and the master must re-issue.
- Reset values: `m0_ack`=0, `m1_ack`=0, `m0_rddata`=0, `m1_rddata`=0.

## Structure
- Shared package holds the state encodings (`IDLE`, `ACK`), the port index constants (`PORT_DISPLAY`=0, `PORT_HOST`=1) and the default `ADDR_W`.
- One sub-module, `vram_sram`: single-port synchronous RAM with 32-bit data, per-byte write enables and a registered read output. It is inferable or a vendor SPRAM wrapper.
- Arbiter and FSM stay in the top level, about 150 lines.

## Test plan
- Port 1 writes 0xDEADBEEF to byte address 0x00100 with bytesel 0xF, then port 0 reads 0x00100 -> each ack arrives 1 cycle after its strobe and `m0_rddata`=0xDEADBEEF.
- Port 1 writes 0x000000AA to 0x00200 with bytesel 0x1 over preload 0x11223344, then reads it back -> 0x112233AA.
- Both strobes held high for 8 transactions -> grants go 0,1,0,1,...; the first grant after reset is port 0; no port waits more than 3 cycles.
- Port 0 strobes addresses 0x00103 and 0x00100 -> both return the same word, since the low bits are ignored. Address 0x3FFFC reaches the top word with no aliasing to word 0.
- Reset pulsed during ACK of a port 1 write of 0x55 to 0x00300 -> `m1_ack`=0 the next cycle, the FSM is in IDLE, and a later read of 0x00300 returns 0x55.
- Strobe raised for 1 cycle during ACK, then dropped -> no ack is ever issued to that port.

Source files
------------

// File: rtl/vram_bus_responder_pkg.sv
// Shared constants for the VRAM bus responder: FSM state encodings,
// master port indices and the default byte-address width.
package vram_bus_responder_pkg;

  localparam int ADDR_W_DEFAULT = 18;

  // FSM state encodings (kept as plain constants for legacy tools)
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] ACK  = 1'b1;

  // Master port indices
  localparam logic [0:0] PORT_DISPLAY = 1'b0;
  localparam logic [0:0] PORT_HOST    = 1'b1;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/vram_bus_responder_sram.sv
// Single-port synchronous VRAM: 32-bit words, per-byte write enables and a
// registered read output. Array contents are never cleared by reset; only
// the read-data register returns to zero.
module vram_sram
  import vram_bus_responder_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [3:0]    bytesel,
  input  word_t         wrdata,
  output word_t         rddata
);

  localparam int DEPTH = 1 << AW;

  word_t mem_r [0:DEPTH-1];
  word_t rddata_r;

  // Byte-masked write into the array; only enabled lanes are updated
  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (bytesel[i]) begin
          mem_r[addr][8*i +: 8] <= wrdata[8*i +: 8];
        end
      end
    end
  end

  // Read register: captures the addressed word on a read access and holds it otherwise
  always_ff @(posedge clk) begin
    if (rst) begin
      rddata_r <= 32'h0000_0000;
    end else if (en && !we) begin
      rddata_r <= mem_r[addr];
    end
  end

  assign rddata = rddata_r;

endmodule

// File: rtl/vram_bus_responder.sv
// VRAM bus responder: round-robin arbitration of the display fetch port
// (read-only) and the host port (read/write) onto one single-port VRAM.
// Each granted request is acknowledged with a one-cycle pulse the cycle
// after it is seen in IDLE.
module vram_bus_responder
  import vram_bus_responder_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic              m0_strobe,
  output logic [31:0]       m0_rddata,
  output logic              m0_ack,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic              m1_strobe,
  input  logic              m1_write,
  input  logic [3:0]        m1_wrbytesel,
  input  logic [31:0]       m1_wrdata,
  output logic [31:0]       m1_rddata,
  output logic              m1_ack
);

  localparam int WORD_AW = ADDR_W - 2;

  logic [0:0]         state_r;
  logic [0:0]         grant_r;
  logic [0:0]         last_grant_r;

  logic               win_valid_s;
  logic [0:0]         win_port_s;
  logic               ram_en_s;
  logic               ram_we_s;
  logic [WORD_AW-1:0] ram_addr_s;
  logic [3:0]         ram_bytesel_s;
  word_t              ram_wrdata_s;
  word_t              ram_rddata_s;

  // Byte-offset bits do not take part in word addressing
  logic               unused_addr_bits_s;
  assign unused_addr_bits_s = ^{m0_addr[1:0], m1_addr[1:0]};

  // Arbitration: a lone requester wins; on contention the port not served last wins
  always_comb begin
    win_valid_s = 1'b0;
    win_port_s  = PORT_DISPLAY;
    if (state_r == IDLE) begin
      if (m0_strobe && m1_strobe) begin
        win_valid_s = 1'b1;
        win_port_s  = ~last_grant_r;
      end else if (m0_strobe) begin
        win_valid_s = 1'b1;
        win_port_s  = PORT_DISPLAY;
      end else if (m1_strobe) begin
        win_valid_s = 1'b1;
        win_port_s  = PORT_HOST;
      end else begin
        win_valid_s = 1'b0;
        win_port_s  = PORT_DISPLAY;
      end
    end else begin
      win_valid_s = 1'b0;
      win_port_s  = PORT_DISPLAY;
    end
  end

  // RAM request mux: the winner's word address and, for the host, its write fields
  always_comb begin
    ram_en_s      = win_valid_s && !rst;
    ram_we_s      = 1'b0;
    ram_addr_s    = m0_addr[ADDR_W-1:2];
    ram_bytesel_s = 4'h0;
    ram_wrdata_s  = 32'h0000_0000;
    if (win_port_s == PORT_HOST) begin
      ram_addr_s    = m1_addr[ADDR_W-1:2];
      ram_we_s      = ram_en_s && m1_write;
      ram_bytesel_s = m1_wrbytesel;
      ram_wrdata_s  = m1_wrdata;
    end else begin
      ram_addr_s    = m0_addr[ADDR_W-1:2];
      ram_we_s      = 1'b0;
      ram_bytesel_s = 4'h0;
      ram_wrdata_s  = 32'h0000_0000;
    end
  end

  // Two-state FSM: IDLE grants a request, ACK returns the completion pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      grant_r      <= PORT_DISPLAY;
      last_grant_r <= PORT_HOST;
    end else begin
      case (state_r)
        IDLE: begin
          if (win_valid_s) begin
            state_r      <= ACK;
            grant_r      <= win_port_s;
            last_grant_r <= win_port_s;
          end
        end
        ACK: begin
          state_r <= IDLE;
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  vram_sram #(
    .AW (WORD_AW)
  ) u_sram (
    .clk     (clk),
    .rst     (rst),
    .en      (ram_en_s),
    .we      (ram_we_s),
    .addr    (ram_addr_s),
    .bytesel (ram_bytesel_s),
    .wrdata  (ram_wrdata_s),
    .rddata  (ram_rddata_s)
  );

  // Acks decode purely from flops; both ports see the shared read register
  assign m0_ack    = (state_r == ACK) && (grant_r == PORT_DISPLAY);
  assign m1_ack    = (state_r == ACK) && (grant_r == PORT_HOST);
  assign m0_rddata = ram_rddata_s;
  assign m1_rddata = ram_rddata_s;

endmodule
